// File: rtl/load_store_unit.sv
// Byte/half/word load-store front end for a word-wide memory; sub-word stores use read-modify-write.
// Latency accept->done: error 1, word store 2, load 3, sub-word store 4, plus ack stalls; req_i ignored while busy.
module load_store_unit #(
    parameter bit CHECK_ALIGN = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_i,
    input  logic        we_i,
    input  logic [1:0]  size_i,
    input  logic        unsigned_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] rdata_o,
    output logic        done_o,
    output logic        err_o,
    output logic        busy_o,
    output logic        mem_rd_en_o,
    output logic        mem_wr_en_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_data_o,
    input  logic [31:0] mem_data_i,
    input  logic        mem_ack_i
);

    typedef enum logic [2:0] {IDLE, READ, CAPTURE, MERGE, WRITE, DONE} state_t;

    state_t      state;
    logic        we_q;
    logic        uns_q;
    logic [1:0]  size_q;
    logic [1:0]  lane_q;
    logic [15:0] wdata_q;

    logic        misaligned;
    logic        req_err;
    logic [4:0]  sh_amt;
    logic [31:0] lane_sh;
    logic [31:0] load_ext;
    logic [31:0] merged;

    assign misaligned = CHECK_ALIGN && ((size_i == 2'b01 && addr_i[0]) ||
                                        (size_i == 2'b10 && addr_i[1:0] != 2'b00));
    assign req_err    = (size_i == 2'b11) || misaligned;

    // Lane selection uses only the latched address bits; with alignment checks off,
    // a half ignores addr[0] and a word ignores both low bits.
    always_comb begin
        sh_amt   = 5'd0;
        load_ext = mem_data_i;
        merged   = mem_data_i;
        case (size_q)
            2'b00: sh_amt = {lane_q, 3'b000};
            2'b01: sh_amt = {lane_q[1], 4'b0000};
            default: sh_amt = 5'd0;
        endcase
        lane_sh = mem_data_i >> sh_amt;
        case (size_q)
            2'b00: begin
                load_ext = {{24{~uns_q & lane_sh[7]}}, lane_sh[7:0]};
                case (lane_q)
                    2'd0: merged[7:0]   = wdata_q[7:0];
                    2'd1: merged[15:8]  = wdata_q[7:0];
                    2'd2: merged[23:16] = wdata_q[7:0];
                    default: merged[31:24] = wdata_q[7:0];
                endcase
            end
            2'b01: begin
                load_ext = {{16{~uns_q & lane_sh[15]}}, lane_sh[15:0]};
                if (lane_q[1]) merged[31:16] = wdata_q;
                else           merged[15:0]  = wdata_q;
            end
            default: load_ext = lane_sh;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            we_q        <= 1'b0;
            uns_q       <= 1'b0;
            size_q      <= 2'b00;
            lane_q      <= 2'b00;
            wdata_q     <= 16'h0;
            rdata_o     <= 32'h0;
            done_o      <= 1'b0;
            err_o       <= 1'b0;
            busy_o      <= 1'b0;
            mem_rd_en_o <= 1'b0;
            mem_wr_en_o <= 1'b0;
            mem_addr_o  <= 32'h0;
            mem_data_o  <= 32'h0;
        end else begin
            done_o <= 1'b0;
            err_o  <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_i) begin
                        we_q       <= we_i;
                        uns_q      <= unsigned_i;
                        size_q     <= size_i;
                        lane_q     <= addr_i[1:0];
                        wdata_q    <= wdata_i[15:0];
                        mem_addr_o <= {addr_i[31:2], 2'b00};
                        mem_data_o <= wdata_i;
                        busy_o     <= 1'b1;
                        if (req_err) begin
                            state   <= DONE;
                            done_o  <= 1'b1;
                            err_o   <= 1'b1;
                            rdata_o <= 32'h0;
                        end else if (we_i && size_i == 2'b10) begin
                            state       <= WRITE;
                            mem_wr_en_o <= 1'b1;
                        end else begin
                            state       <= READ;
                            mem_rd_en_o <= 1'b1;
                        end
                    end
                end
                READ: begin
                    if (mem_ack_i) begin
                        mem_rd_en_o <= 1'b0;
                        state       <= we_q ? MERGE : CAPTURE;
                    end
                end
                CAPTURE: begin
                    rdata_o <= load_ext;
                    done_o  <= 1'b1;
                    state   <= DONE;
                end
                MERGE: begin
                    mem_data_o  <= merged;
                    mem_wr_en_o <= 1'b1;
                    state       <= WRITE;
                end
                WRITE: begin
                    if (mem_ack_i) begin
                        mem_wr_en_o <= 1'b0;
                        done_o      <= 1'b1;
                        state       <= DONE;
                    end
                end
                DONE: begin
                    busy_o <= 1'b0;
                    state  <= IDLE;
                end
                default: begin
                    mem_rd_en_o <= 1'b0;
                    mem_wr_en_o <= 1'b0;
                    busy_o      <= 1'b0;
                    state       <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Randomized bench for load_store_unit against an arithmetic reference model of memory and load results.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req, we, uns;
    logic [1:0]  size;
    logic [31:0] addr, wdata;
    logic [31:0] rdata, maddr, mdata_o;
    logic        done, err, busy, rd_en, wr_en, mem_ack;
    logic [31:0] mem_rdata;

    logic        req2, we2, uns2;
    logic [1:0]  size2;
    logic [31:0] addr2, wdata2;
    logic [31:0] rdata2, maddr2, mdata_o2, mem_rdata2;
    logic        done2, err2, busy2, rd_en2, wr_en2;
    logic        mem_ack2;

    logic [31:0] mem     [0:15];
    logic [31:0] ref_mem [0:15];
    logic        bd_we;
    logic [3:0]  bd_idx;
    logic [31:0] bd_dat;
    int          rd_cnt;
    int          stall_cfg;
    logic [31:0] last_rdata;
    int          n_chk = 0;
    int          n_err = 0;

    always #5 clk = ~clk;

    load_store_unit #(.CHECK_ALIGN(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .req_i(req), .we_i(we), .size_i(size), .unsigned_i(uns),
        .addr_i(addr), .wdata_i(wdata), .rdata_o(rdata), .done_o(done), .err_o(err),
        .busy_o(busy), .mem_rd_en_o(rd_en), .mem_wr_en_o(wr_en), .mem_addr_o(maddr),
        .mem_data_o(mdata_o), .mem_data_i(mem_rdata), .mem_ack_i(mem_ack)
    );

    load_store_unit #(.CHECK_ALIGN(1'b0)) dut_na (
        .clk(clk), .rst_n(rst_n), .req_i(req2), .we_i(we2), .size_i(size2), .unsigned_i(uns2),
        .addr_i(addr2), .wdata_i(wdata2), .rdata_o(rdata2), .done_o(done2), .err_o(err2),
        .busy_o(busy2), .mem_rd_en_o(rd_en2), .mem_wr_en_o(wr_en2), .mem_addr_o(maddr2),
        .mem_data_o(mdata_o2), .mem_data_i(mem_rdata2), .mem_ack_i(mem_ack2)
    );

    // Reads stall only while rd_cnt < stall_cfg; writes are always accepted.
    assign mem_ack  = wr_en ? 1'b1 : (rd_cnt >= stall_cfg);
    assign mem_ack2 = 1'b1;

    always @(posedge clk) begin
        if (bd_we) mem[bd_idx] <= bd_dat;
        if (rd_en && mem_ack) mem_rdata <= mem[maddr[5:2]];
        if (wr_en && mem_ack) mem[maddr[5:2]] <= mdata_o;
        mem_rdata2 <= mem[maddr2[5:2]];
        rd_cnt <= (rd_en && !mem_ack) ? rd_cnt + 1 : 0;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic int lane_shift(input logic [1:0] sz, input logic [31:0] a);
        if (sz == 2'd0) return 8 * int'(a[1:0]);
        if (sz == 2'd1) return 16 * int'(a[1]);
        return 0;
    endfunction

    function automatic int size_bits(input logic [1:0] sz);
        return (sz == 2'd0) ? 8 : (sz == 2'd1) ? 16 : 32;
    endfunction

    function automatic logic [31:0] ld_exp(input logic [31:0] word, input logic [1:0] sz,
                                           input logic u, input logic [31:0] a);
        longint v, one;
        int bits;
        one  = 1;
        bits = size_bits(sz);
        v = (longint'(word) >> lane_shift(sz, a)) % (one << bits);
        if (!u && v >= (one << (bits - 1))) v = v - (one << bits);
        return v[31:0];
    endfunction

    function automatic logic [31:0] st_exp(input logic [31:0] word, input logic [1:0] sz,
                                           input logic [31:0] a, input logic [31:0] wd);
        longint mask, one, res;
        int sh;
        one  = 1;
        sh   = lane_shift(sz, a);
        mask = ((one << size_bits(sz)) - 1) << sh;
        res  = (longint'(word) & ~mask) | ((longint'(wd) << sh) & mask);
        return res[31:0];
    endfunction

    task automatic poke(input logic [3:0] idx, input logic [31:0] dat);
        @(negedge clk);
        bd_we = 1'b1; bd_idx = idx; bd_dat = dat;
        ref_mem[idx] = dat;
        @(negedge clk);
        bd_we = 1'b0;
    endtask

    task automatic do_op(input logic w, input logic [1:0] sz, input logic u,
                         input logic [31:0] a, input logic [31:0] wd, input int stall);
        logic        e, got_done;
        logic [3:0]  idx;
        logic [31:0] new_word;
        int          lat_exp, rd_exp, wr_exp, lat, rdc, wrc;
        idx      = a[5:2];
        e        = (sz == 2'd3) || (sz == 2'd1 && a[0]) || (sz == 2'd2 && a[1:0] != 2'b00);
        new_word = ref_mem[idx];
        if (e) begin
            lat_exp = 1; rd_exp = 0; wr_exp = 0; last_rdata = 32'h0;
        end else if (!w) begin
            lat_exp = 3 + stall; rd_exp = 1 + stall; wr_exp = 0;
            last_rdata = ld_exp(ref_mem[idx], sz, u, a);
        end else if (sz == 2'd2) begin
            lat_exp = 2; rd_exp = 0; wr_exp = 1; new_word = wd;
        end else begin
            lat_exp = 4 + stall; rd_exp = 1 + stall; wr_exp = 1;
            new_word = st_exp(ref_mem[idx], sz, a, wd);
        end
        stall_cfg = stall;
        @(negedge clk);
        req = 1'b1; we = w; size = sz; uns = u; addr = a; wdata = wd;
        @(posedge clk);
        #1 req = 1'b0;
        lat = 0; rdc = 0; wrc = 0; got_done = 1'b0;
        for (int k = 1; k <= 40 && !got_done; k++) begin
            if (k > 1) begin
                @(posedge clk);
                #1;
            end
            chk("one_enable", {31'b0, rd_en & wr_en}, 32'h0);
            if (rd_en) begin
                rdc++;
                chk("rd_addr", maddr, {a[31:2], 2'b00});
            end
            if (wr_en) begin
                wrc++;
                chk("wr_addr", maddr, {a[31:2], 2'b00});
                chk("wr_data", mdata_o, new_word);
            end
            if (done) begin
                got_done = 1'b1;
                lat = k;
                req = 1'b0;
            end else begin
                // Requests while busy must be ignored.
                req = 1'($urandom_range(0, 1)); we = 1'($urandom); size = 2'($urandom);
                uns = 1'($urandom); addr = $urandom; wdata = $urandom;
            end
        end
        if (!got_done) chk("done_timeout", 32'h0, 32'h1);
        ref_mem[idx] = new_word;
        chk("latency", 32'(lat), 32'(lat_exp));
        chk("rd_cycles", 32'(rdc), 32'(rd_exp));
        chk("wr_cycles", 32'(wrc), 32'(wr_exp));
        chk("err", {31'b0, err}, {31'b0, e});
        chk("rdata", rdata, last_rdata);
        chk("mem", mem[idx], ref_mem[idx]);
        @(posedge clk);
        #1;
        chk("idle_busy", {31'b0, busy}, 32'h0);
        chk("rdata_hold", rdata, last_rdata);
    endtask

    task automatic do_op_na(input logic [1:0] sz, input logic u, input logic [31:0] a);
        logic got_done;
        got_done = 1'b0;
        @(negedge clk);
        req2 = 1'b1; we2 = 1'b0; size2 = sz; uns2 = u; addr2 = a; wdata2 = 32'h0;
        @(posedge clk);
        #1 req2 = 1'b0;
        for (int k = 1; k <= 20 && !got_done; k++) begin
            if (k > 1) begin
                @(posedge clk);
                #1;
            end
            if (done2) got_done = 1'b1;
        end
        if (!got_done) chk("na_timeout", 32'h0, 32'h1);
        chk("na_err", {31'b0, err2}, 32'h0);
        chk("na_rdata", rdata2, ld_exp(ref_mem[a[5:2]], sz, u, a));
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0; req = 1'b0; we = 1'b0; size = 2'b00; uns = 1'b0; addr = 32'h0; wdata = 32'h0;
        req2 = 1'b0; we2 = 1'b0; size2 = 2'b00; uns2 = 1'b0; addr2 = 32'h0; wdata2 = 32'h0;
        bd_we = 1'b0; bd_idx = 4'h0; bd_dat = 32'h0; stall_cfg = 0; last_rdata = 32'h0;
        for (int i = 0; i < 16; i++) poke(4'(i), $urandom);
        poke(4'd2, 32'hDEADBEEF);
        #1;
        chk("rst_rdata", rdata, 32'h0);
        chk("rst_flags", {26'b0, done, err, busy, rd_en, wr_en, 1'b0}, 32'h0);
        chk("rst_addr", maddr, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        do_op(1'b0, 2'd0, 1'b0, 32'h9, 32'h0, 0);
        chk("byte_signed_const", rdata, 32'hFFFFFFBE);
        do_op(1'b0, 2'd0, 1'b1, 32'h9, 32'h0, 0);
        chk("byte_unsigned_const", rdata, 32'h000000BE);
        do_op(1'b0, 2'd1, 1'b0, 32'hA, 32'h0, 0);
        chk("half_signed_const", rdata, 32'hFFFFDEAD);
        do_op(1'b0, 2'd2, 1'b0, 32'h8, 32'h0, 0);
        chk("word_const", rdata, 32'hDEADBEEF);
        do_op(1'b1, 2'd0, 1'b0, 32'hA, 32'h55, 0);
        chk("store_byte_const", mem[2], 32'hDE55BEEF);
        do_op(1'b1, 2'd2, 1'b0, 32'h10, 32'h12345678, 0);
        chk("store_word_const", mem[4], 32'h12345678);
        do_op(1'b0, 2'd1, 1'b0, 32'h3, 32'h0, 0);
        do_op(1'b0, 2'd3, 1'b0, 32'h8, 32'h0, 0);
        do_op(1'b1, 2'd2, 1'b0, 32'hA, 32'hFFFFFFFF, 0);
        do_op(1'b0, 2'd2, 1'b0, 32'h8, 32'h0, 3);
        do_op(1'b1, 2'd1, 1'b0, 32'h22, 32'hABCD, 2);

        do_op_na(2'd2, 1'b0, 32'hB);
        do_op_na(2'd1, 1'b1, 32'h3);

        for (int i = 0; i < 60; i++) begin
            logic [1:0] sz;
            sz = ($urandom_range(0, 7) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
            do_op(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)),
                  32'($urandom_range(0, 63)), $urandom, $urandom_range(0, 2));
        end

        // Reset while an RMW sits in MERGE: nothing may be written.
        do_op(1'b0, 2'd2, 1'b0, 32'h4, 32'h0, 0);
        stall_cfg = 0;
        @(negedge clk);
        req = 1'b1; we = 1'b1; size = 2'd1; uns = 1'b0; addr = 32'h8; wdata = 32'h0000A5A5;
        @(posedge clk);
        #1 req = 1'b0;
        @(posedge clk);
        #1;
        chk("merge_busy", {31'b0, busy}, 32'h1);
        rst_n = 1'b0;
        #1;
        chk("arst_flags", {27'b0, done, err, busy, rd_en, wr_en}, 32'h0);
        chk("arst_rdata", rdata, 32'h0);
        last_rdata = 32'h0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("arst_mem", mem[2], ref_mem[2]);
        do_op(1'b0, 2'd2, 1'b0, 32'h8, 32'h0, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
